// File: rtl/dec_entry.sv
// dec_entry: keypad number-entry front end.
// Collects up to NDIG decimal key codes plus a sign, echoes the entry in BCD for the display
// path and, on ENTER, converts it serially (reverse double-dabble, 4*NDIG steps) into a
// DATA_W-bit two's-complement value.
//
// Optional feature macro: ENTRY_ERR_EN (adds the sticky 'err' output).
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active-low
//   sel        module select; keys are accepted only while high
//   key_valid  single-cycle key strobe
//   key_code   0-9 digit, 4'hA sign toggle, 4'hB ENTER, 4'hC CLEAR, others ignored
//   busy       high while converting
//   out_valid  one-cycle pulse when data_out is updated
//   data_out   signed result, held between conversions
//   bcd_echo   current entry, least-significant digit in [3:0]
//   err        (ENTRY_ERR_EN only) sticky: digit rejected or key pressed while busy
//   sign_echo  1 = entry is negative
module dec_entry #(
   parameter int unsigned NDIG   = 3,
   parameter int unsigned DATA_W = 11
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sel,
   input  logic                key_valid,
   input  logic [3:0]          key_code,
   output logic                busy,
   output logic                out_valid,
   output logic [DATA_W-1:0]   data_out,
   output logic [4*NDIG-1:0]   bcd_echo,
`ifdef ENTRY_ERR_EN
   output logic                err,
`endif
   output logic                sign_echo
);

   localparam int unsigned BW    = 4 * NDIG;
   localparam int unsigned STEPS = BW;
   localparam int unsigned CW    = $clog2(NDIG + 1);
   localparam int unsigned SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic [1:0] {StEntry, StConv, StDone} state_t;

   state_t            state;
   logic [CW-1:0]     count;
   logic [BW-1:0]     work_bcd;
   logic [BW-1:0]     bin;
   logic              work_sign;
   logic [SW-1:0]     step;

   logic              accept;
   logic              is_digit;
   logic [2*BW-1:0]   shifted;
   logic [BW-1:0]     next_bcd;
   logic [BW-1:0]     next_bin;
   logic [DATA_W-1:0] mag;
   logic [DATA_W-1:0] result;

   assign accept   = key_valid && sel && (state == StEntry);
   assign is_digit = (key_code < 4'hA);

   // One reverse double-dabble step: shift {bcd, bin} right, then pull every BCD nibble that
   // reached 8 or more back by 3 (undoing the doubling correction of the forward algorithm).
   always_comb begin
      shifted  = {work_bcd, bin} >> 1;
      next_bin = shifted[BW-1:0];
      next_bcd = shifted[2*BW-1:BW];
      for (int i = 0; i < int'(NDIG); i++) begin
         if (next_bcd[4*i +: 4] >= 4'd8) begin
            next_bcd[4*i +: 4] = next_bcd[4*i +: 4] - 4'd3;
         end
      end
   end

   // -0 naturally negates to 0, so no special case is needed.
   always_comb begin
      mag    = DATA_W'(bin);
      result = work_sign ? (-mag) : mag;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= StEntry;
         count     <= '0;
         work_bcd  <= '0;
         bin       <= '0;
         work_sign <= 1'b0;
         step      <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         data_out  <= '0;
         bcd_echo  <= '0;
         sign_echo <= 1'b0;
`ifdef ENTRY_ERR_EN
         err       <= 1'b0;
`endif
      end else begin
         out_valid <= 1'b0;
`ifdef ENTRY_ERR_EN
         if (key_valid && sel && busy) begin
            err <= 1'b1;
         end
`endif
         case (state)
            StEntry: begin
               if (accept) begin
                  if (is_digit) begin
                     if (count < CW'(NDIG)) begin
                        bcd_echo <= (bcd_echo << 4) | BW'(key_code);
                        count    <= count + CW'(1);
                     end
`ifdef ENTRY_ERR_EN
                     else begin
                        err <= 1'b1;
                     end
`endif
                  end else begin
                     case (key_code)
                        4'hA: sign_echo <= ~sign_echo;
                        4'hB: begin
                           // Echo registers stay frozen on the latched entry until DONE.
                           work_bcd  <= bcd_echo;
                           work_sign <= sign_echo;
                           bin       <= '0;
                           step      <= '0;
                           busy      <= 1'b1;
                           state     <= StConv;
                        end
                        4'hC: begin
                           bcd_echo  <= '0;
                           sign_echo <= 1'b0;
                           count     <= '0;
`ifdef ENTRY_ERR_EN
                           err       <= 1'b0;
`endif
                        end
                        default: ;
                     endcase
                  end
               end
            end
            StConv: begin
               work_bcd <= next_bcd;
               bin      <= next_bin;
               step     <= step + SW'(1);
               if (step == SW'(STEPS - 1)) begin
                  busy  <= 1'b0;
                  state <= StDone;
               end
            end
            StDone: begin
               data_out  <= result;
               out_valid <= 1'b1;
               bcd_echo  <= '0;
               sign_echo <= 1'b0;
               count     <= '0;
`ifdef ENTRY_ERR_EN
               err       <= 1'b0;
`endif
               state     <= StEntry;
            end
            default: state <= StEntry;
         endcase
      end
   end

endmodule

// File: tb/tb_dec_entry.sv
// Bench for dec_entry: directed scenarios plus random entries, checked against a decimal
// model (value = value*10 + digit). Expected results go into a queue; a monitor pops and
// compares whenever out_valid is seen.
module tb_dec_entry;

   localparam int NDIG   = 3;
   localparam int DATA_W = 11;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                sel = 1'b0;
   logic                key_valid = 1'b0;
   logic [3:0]          key_code = 4'h0;
   logic                busy;
   logic                out_valid;
   logic [DATA_W-1:0]   data_out;
   logic [4*NDIG-1:0]   bcd_echo;
   logic                sign_echo;
`ifdef ENTRY_ERR_EN
   logic                err;
`endif

   dec_entry #(.NDIG(NDIG), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .sel       (sel),
      .key_valid (key_valid),
      .key_code  (key_code),
      .busy      (busy),
      .out_valid (out_valid),
      .data_out  (data_out),
      .bcd_echo  (bcd_echo),
`ifdef ENTRY_ERR_EN
      .err       (err),
`endif
      .sign_echo (sign_echo)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [DATA_W-1:0] exp_q[$];

   // Reference model state
   int m_val  = 0;
   int m_cnt  = 0;
   bit m_sign = 0;
   bit m_err  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [4*NDIG-1:0] to_bcd(input int v);
      logic [4*NDIG-1:0] r;
      r = '0;
      for (int i = 0; i < NDIG; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // Monitor: every out_valid must match the oldest queued expectation and last one cycle.
   bit ov_prev = 0;
   always @(posedge clk) begin
      #1;
      if (out_valid) begin
         chk("out_valid_pulse_width", 32'(ov_prev), 32'd0);
         if (exp_q.size() == 0) begin
            chk("out_valid_unexpected", 32'd1, 32'd0);
         end else begin
            chk("data_out", 32'(data_out), 32'(exp_q.pop_front()));
         end
      end
      ov_prev = out_valid;
   end

   task automatic model_clear();
      m_val  = 0;
      m_cnt  = 0;
      m_sign = 0;
      m_err  = 0;
   endtask

   task automatic press(input logic [3:0] code, input logic s);
      @(negedge clk);
      key_code  = code;
      sel       = s;
      key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0;
      if (s) begin
         if (code < 4'hA) begin
            if (m_cnt < NDIG) begin
               m_val = m_val * 10 + int'(code);
               m_cnt++;
            end else begin
               m_err = 1;
            end
         end else if (code == 4'hA) begin
            m_sign = !m_sign;
         end else if (code == 4'hC) begin
            model_clear();
         end
      end
      chk("bcd_echo", 32'(bcd_echo), 32'(to_bcd(m_val)));
      chk("sign_echo", 32'(sign_echo), 32'(m_sign));
`ifdef ENTRY_ERR_EN
      chk("err", 32'(err), 32'(m_err));
`endif
   endtask

   // Issue ENTER, optionally poke keys 2 and 5 while busy, then check latency and busy length.
   task automatic do_enter(input bit inject);
      logic [DATA_W-1:0] e;
      int n;
      int bc;
      bit done;
      e = m_sign ? DATA_W'(-m_val) : DATA_W'(m_val);
      exp_q.push_back(e);
      @(negedge clk);
      key_code  = 4'hB;
      sel       = 1'b1;
      key_valid = 1'b1;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      n    = 0;
      bc   = 0;
      done = 0;
      while (n < 40 && !done) begin
         if (out_valid) begin
            done = 1;
         end else begin
            if (busy) bc++;
            if (n == 1) chk("echo_frozen", 32'(bcd_echo), 32'(to_bcd(m_val)));
            if (inject) begin
               case (n)
                  2: begin key_code = 4'h2; key_valid = 1'b1; end
                  3: key_valid = 1'b0;
                  5: begin key_code = 4'h5; key_valid = 1'b1; end
                  6: key_valid = 1'b0;
                  default: ;
               endcase
            end
            @(posedge clk);
            #1;
            n++;
         end
      end
      chk("latency", 32'(n), 32'd13);
      chk("busy_cycles", 32'(bc), 32'd12);
      chk("busy_at_done", 32'(busy), 32'd0);
      model_clear();
      @(negedge clk);
      chk("bcd_after_done", 32'(bcd_echo), 32'd0);
      chk("sign_after_done", 32'(sign_echo), 32'd0);
`ifdef ENTRY_ERR_EN
      chk("err_after_done", 32'(err), 32'd0);
`endif
   endtask

   initial begin
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_data_out", 32'(data_out), 32'd0);
      chk("rst_bcd", 32'(bcd_echo), 32'd0);
      chk("rst_sign", 32'(sign_echo), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // 123
      press(4'h1, 1'b1); press(4'h2, 1'b1); press(4'h3, 1'b1);
      do_enter(0);
      // -999
      press(4'h9, 1'b1); press(4'h9, 1'b1); press(4'h9, 1'b1); press(4'hA, 1'b1);
      do_enter(0);
      // 456, fourth digit rejected
      press(4'h4, 1'b1); press(4'h5, 1'b1); press(4'h6, 1'b1); press(4'h7, 1'b1);
      do_enter(0);
      // -0 yields 0
      press(4'hA, 1'b1); press(4'h0, 1'b1);
      do_enter(0);
      // CLEAR discards the 5
      press(4'h5, 1'b1); press(4'hC, 1'b1); press(4'h7, 1'b1);
      do_enter(0);
      // sel low ignores the key; ignored codes D-F
      press(4'h3, 1'b0); press(4'hD, 1'b1); press(4'hF, 1'b1);
      // keys during busy are dropped
      press(4'h4, 1'b1); press(4'h2, 1'b1);
      do_enter(1);

      // Reset in the 5th conversion cycle: no result may appear
      press(4'h8, 1'b1); press(4'h8, 1'b1);
      @(negedge clk);
      key_code  = 4'hB;
      sel       = 1'b1;
      key_valid = 1'b1;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_data_out", 32'(data_out), 32'd0);
      chk("midrst_bcd", 32'(bcd_echo), 32'd0);
      chk("midrst_sign", 32'(sign_echo), 32'd0);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      model_clear();
      @(negedge clk);
      rst = 1'b1;
      repeat (20) @(posedge clk);

      // Random entries
      for (int t = 0; t < 30; t++) begin
         int nk;
         nk = int'($urandom_range(0, 6));
         for (int k = 0; k < nk; k++) begin
            logic [3:0] c;
            c = 4'($urandom_range(0, 15));
            if (c == 4'hB) c = 4'hA;
            press(c, ($urandom_range(0, 3) != 0));
         end
         do_enter(0);
      end

      repeat (3) @(posedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dec_entry.md
Name: dec_entry

Overview:
- Keypad/number-entry front end. It is the input-side counterpart of the 7-segment display driver.
- Accepts decimal key codes one per strobe and holds up to NDIG BCD digits plus a sign.
- On ENTER, converts the entry serially (reverse double-dabble) to a DATA_W-bit two's-complement number for the datapath.
- Echoes the current entry in BCD so the display path can show it.

Parameters:
- NDIG, 3, maximum decimal digits held; 10^NDIG-1 must be <= 2^(DATA_W-1)-1.
- DATA_W, 11, width of the signed binary result.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- sel  input  1  module select; keys are accepted only while high
- key_valid  input  1  single-cycle key strobe
- key_code  input  4  0-9 = digit; 4'hA = sign toggle; 4'hB = ENTER; 4'hC = CLEAR; others = ignored
- busy  output  1  high while converting
- out_valid  output  1  one-cycle pulse when data_out is updated
- data_out  output  DATA_W  signed result; holds its value between conversions
- bcd_echo  output  4*NDIG  current entry; least-significant digit in [3:0]
- sign_echo  output  1  1 = entry is negative

Behaviour:
- Reset (rst low, asynchronous): state=ENTRY, busy=0, out_valid=0, data_out=0, bcd_echo=0, sign_echo=0, digit count=0.
- A key is accepted when key_valid=1, sel=1 and state=ENTRY. In any other case it is ignored with no state change.
- ENTRY state:
  - Digit, count<NDIG: bcd_echo shifts left one nibble, new digit enters [3:0], count+1. Leading zeros consume a slot.
  - Digit, count==NDIG: ignored.
  - 4'hA: sign_echo toggles.
  - 4'hC: bcd_echo=0, sign_echo=0, count=0.
  - 4'hB: latch bcd_echo and sign_echo into the working register; binary accumulator=0; step counter=0; go to CONV; busy=1 from the next cycle.
  - ENTER with count==0 converts 0.
- CONV state: exactly 4*NDIG cycles. Each cycle:
  - Shift {bcd, bin} right by 1; the bcd LSB enters the bin MSB side.
  - Then subtract 3 from every BCD nibble whose value is >=8.
  - After the last step, bin[DATA_W-1:0] holds the magnitude; go to DONE.
- DONE state, one cycle:
  - data_out = sign ? -mag : mag (DATA_W-bit two's complement).
  - A -0 entry yields 0.
  - out_valid=1 for this cycle only; busy=0.
  - Entry register, sign and count are cleared; return to ENTRY.
- Latency: ENTER sampled at edge k gives out_valid high in the cycle after edge k+4*NDIG+1. For NDIG=3 this is 13 cycles.
- sel dropping during CONV/DONE does not abort the conversion. Keys during CONV/DONE are dropped.
- Reset asserted mid-conversion: immediate return to reset values; no out_valid is produced.
- bcd_echo/sign_echo are frozen to the latched entry during CONV and read 0 after DONE.
- Key codes 4'hD-4'hF are ignored in all states.

Optional Feature:
- Macro: ENTRY_ERR_EN.
- Defined: adds output port err (1 bit).
  - err is set sticky on a rejected digit (entry full).
  - err is also set on any key strobe with sel=1 while busy.
  - err is cleared by CLEAR, by a completed conversion (DONE), or by reset; reset value 0.
- Undefined: no err port; rejected keys are silently dropped. All other behaviour is identical.

Test Plan:
- Keys 1,2,3,ENTER -> busy=1 for 12 cycles; out_valid after 13 cycles; data_out=11'h07B (123).
- Keys 9,9,9,A,ENTER -> sign_echo=1 before ENTER; data_out=11'h419 (-999); out_valid for exactly 1 cycle.
- Keys 4,5,6,7,ENTER -> 7 ignored; bcd_echo=12'h456 before ENTER; data_out=11'h1C8.
  - With ENTRY_ERR_EN: err=1 after key 7, err=0 after DONE.
- Keys A,0,ENTER -> data_out=11'h000, not 11'h400. Then keys 5,C,7,ENTER -> data_out=11'h007.
- Key 3 with sel=0 -> bcd_echo unchanged at 0. Keys 2 and 5 sent with sel=1 during busy -> ignored; result of the prior entry is unaffected.
- Keys 8,8,ENTER, then rst low during the 5th CONV cycle -> busy=0, data_out=0, echoes 0; no out_valid pulse.
